// File: rtl/clk_div_pkg.sv
// Shared types and default parameters for the run-time programmable clock divider.
package clk_div_pkg;

  localparam int DIV_W_DEF       = 8;
  localparam int DEFAULT_DIV_DEF = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PENDING = 2'd2,
    DRAIN   = 2'd3
  } state_t;

endpackage

// File: rtl/clk_div_ctrl.sv
// Programmable 50%-duty clock divider with tick strobe; divisor updates, enable
// and disable all take effect only on full-period boundaries.
module clk_div_ctrl
  import clk_div_pkg::*;
#(
  parameter int DIV_W       = DIV_W_DEF,
  parameter int DEFAULT_DIV = DEFAULT_DIV_DEF
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             en,
  input  logic             cfg_valid,
  input  logic [DIV_W-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             clk_out,
  output logic             tick,
  output logic             active,
  output logic [DIV_W-1:0] cur_div
);

  localparam logic [DIV_W-1:0] ONE      = DIV_W'(1);
  localparam logic [DIV_W-1:0] DIV_INIT = DIV_W'(DEFAULT_DIV);

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] pend_q, pend_d;
  logic             pend_flag, pend_flag_d;
  logic [DIV_W-1:0] cnt, cnt_d;
  logic             clk_d, tick_d, err_d, ready_d, active_d;

  logic xfer, xfer_ok, boundary, rise, fall;

  // div_q is never 0, so div_q - 1 cannot wrap.
  assign xfer     = cfg_valid && cfg_ready;
  assign xfer_ok  = xfer && (cfg_div != '0);
  assign boundary = (cnt == (div_q - ONE));
  assign rise     = boundary && !clk_out;
  assign fall     = boundary && clk_out;

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves
    // a value unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    div_d       = div_q;
    pend_d      = pend_q;
    pend_flag_d = pend_flag;
    cnt_d       = boundary ? '0 : cnt + ONE;
    clk_d       = clk_out ^ boundary;
    tick_d      = rise;
    err_d       = xfer && (cfg_div == '0);

    unique case (state_q)
      IDLE: begin
        cnt_d  = '0;
        clk_d  = 1'b0;
        tick_d = 1'b0;
        if (xfer_ok) div_d = cfg_div;
        if (en) state_d = RUN;
      end

      RUN: begin
        // A transfer wins over en falling; the disable is handled from PENDING.
        if (xfer_ok) begin
          pend_d      = cfg_div;
          pend_flag_d = 1'b1;
          state_d     = PENDING;
        end else if (!en) begin
          if (!clk_out) begin
            state_d = IDLE;
            cnt_d   = '0;
            clk_d   = 1'b0;
            tick_d  = 1'b0;
          end else if (fall) begin
            state_d = IDLE;
          end else begin
            state_d = DRAIN;
          end
        end
      end

      PENDING: begin
        if (fall) begin
          div_d       = pend_q;
          pend_flag_d = 1'b0;
          state_d     = en ? RUN : IDLE;
        end else if (!en) begin
          if (!clk_out) begin
            div_d       = pend_q;
            pend_flag_d = 1'b0;
            state_d     = IDLE;
            cnt_d       = '0;
            clk_d       = 1'b0;
            tick_d      = 1'b0;
          end else begin
            state_d = DRAIN;
          end
        end
      end

      DRAIN: begin
        // en is ignored here; IDLE restarts the divider once the period ends.
        if (fall) begin
          if (pend_flag) div_d = pend_q;
          pend_flag_d = 1'b0;
          state_d     = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        clk_d   = 1'b0;
        tick_d  = 1'b0;
      end
    endcase

    ready_d  = (state_d == IDLE) || (state_d == RUN);
    active_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_in) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    if (rst) begin
      state_q   <= IDLE;
      div_q     <= DIV_INIT;
      pend_q    <= '0;
      pend_flag <= 1'b0;
      cnt       <= '0;
      clk_out   <= 1'b0;
      tick      <= 1'b0;
      cfg_ready <= 1'b1;
      cfg_err   <= 1'b0;
      active    <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      pend_q    <= pend_d;
      pend_flag <= pend_flag_d;
      cnt       <= cnt_d;
      clk_out   <= clk_d;
      tick      <= tick_d;
      cfg_ready <= ready_d;
      cfg_err   <= err_d;
      active    <= active_d;
    end
  end

  assign cur_div = div_q;

endmodule
